// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration in dmem_arb_pick.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF     = 32;
   localparam int DATA_W_DEF     = 32;
   localparam int DEPTH_LOG2_DEF = 10;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - two-way winner selection for dmem_arbiter
// Build option: DMEM_ARB_RR_EN enables round-robin; otherwise port 0 wins ties.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_grant
);

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      if (i_req == 2'b11) begin
         o_grant = ~i_last;
      end else if (i_req[1]) begin
         o_grant = PORT_DMA;
      end else begin
         o_grant = PORT_CPU;
      end
   end
`else
   // Fixed priority has no use for the pointer.
   logic w_unused_last;
   assign w_unused_last = i_last;
   assign o_grant       = (i_req[1] && !i_req[0]) ? PORT_DMA : PORT_CPU;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and one-shot access sequencer for the 1024x32 data memory
// Build option: DMEM_ARB_RR_EN adds the last-grant pointer for round-robin arbitration.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic              p0_err,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic              p1_err,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic              r_we;
   logic              r_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic              w_any_req;
   logic              w_grant;
   logic              w_last;
   logic              w_in_range;
   logic              w_start;

   assign w_any_req  = p0_req | p1_req;
   assign w_start    = (r_state == IDLE) && w_any_req;
   assign w_in_range = (r_addr[ADDR_W-1:DEPTH_LOG2] == '0);

`ifdef DMEM_ARB_RR_EN
   logic r_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= PORT_DMA;
      end else if (w_start) begin
         r_last <= w_grant;
      end
   end

   assign w_last = r_last;
`else
   assign w_last = PORT_DMA;
`endif

   dmem_arb_pick u_pick (
      .i_req   ({p1_req, p0_req}),
      .i_last  (w_last),
      .o_grant (w_grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_any_req) w_next = ACCESS;
         ACCESS:  w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      mem_wr = 1'b0;
      mem_rd = 1'b0;
      p0_ack = 1'b0;
      p1_ack = 1'b0;
      p0_err = 1'b0;
      p1_err = 1'b0;
      case (r_state)
         ACCESS: begin
            mem_wr = r_we & w_in_range;
            mem_rd = ~r_we & w_in_range;
         end
         DONE: begin
            p0_ack = (r_idx == PORT_CPU);
            p1_ack = (r_idx == PORT_DMA);
            p0_err = (r_idx == PORT_CPU) & ~w_in_range;
            p1_err = (r_idx == PORT_DMA) & ~w_in_range;
         end
         default: ;
      endcase
   end

   // Latched request drives the memory bus directly, so it holds between accesses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_idx    <= PORT_CPU;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (w_start) begin
            r_idx   <= w_grant;
            r_we    <= (w_grant == PORT_DMA) ? p1_we    : p0_we;
            r_addr  <= (w_grant == PORT_DMA) ? p1_addr  : p0_addr;
            r_wdata <= (w_grant == PORT_DMA) ? p1_wdata : p0_wdata;
         end
         if (r_state == ACCESS && (!r_we || !w_in_range)) begin
            if (r_idx == PORT_CPU) begin
               r_rdata0 <= w_in_range ? mem_rdata : '0;
            end else begin
               r_rdata1 <= w_in_range ? mem_rdata : '0;
            end
         end
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign p0_rdata  = r_rdata0;
   assign p1_rdata  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter (default build, fixed priority)
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wr, mem_rd;
   logic [31:0] tb_mem [0:1023];

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   assign mem_rdata = tb_mem[mem_addr[9:0]];
   always @(posedge clk) if (mem_wr) tb_mem[mem_addr[9:0]] <= mem_wdata;

   dmem_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_ack    (p0_ack),
      .p0_err    (p0_err),
      .p0_rdata  (p0_rdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_ack    (p1_ack),
      .p1_err    (p1_err),
      .p1_rdata  (p1_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr    (mem_wr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One complete transaction from IDLE: request, ACCESS, DONE, back to IDLE.
   task automatic run(input string tag, input int port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      if (port == 0) begin
         p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      end
      step;
      chk($sformatf("%s_access_wr", tag), {31'd0, mem_wr}, {31'd0, we && !exp_err});
      chk($sformatf("%s_access_rd", tag), {31'd0, mem_rd}, {31'd0, !we && !exp_err});
      if (!exp_err) chk($sformatf("%s_access_addr", tag), mem_addr, addr);
      if (!exp_err && we) chk($sformatf("%s_access_wdata", tag), mem_wdata, wdata);
      step;
      chk($sformatf("%s_done_p0_ack", tag), {31'd0, p0_ack}, {31'd0, port == 0});
      chk($sformatf("%s_done_p1_ack", tag), {31'd0, p1_ack}, {31'd0, port == 1});
      chk($sformatf("%s_done_err", tag), {31'd0, (port == 0) ? p0_err : p1_err}, {31'd0, exp_err});
      chk($sformatf("%s_done_strobes", tag), {30'd0, mem_wr, mem_rd}, 32'd0);
      if (!we) chk($sformatf("%s_done_rdata", tag), (port == 0) ? p0_rdata : p1_rdata, exp_rdata);
      p0_req = 1'b0;
      p1_req = 1'b0;
      step;
      chk($sformatf("%s_idle_acks", tag), {30'd0, p1_ack, p0_ack}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
      #3;
      chk("rst_mem_addr",  mem_addr,  32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_strobes",   {30'd0, mem_wr, mem_rd}, 32'd0);
      chk("rst_acks",      {30'd0, p1_ack, p0_ack}, 32'd0);
      chk("rst_errs",      {30'd0, p1_err, p0_err}, 32'd0);
      chk("rst_p0_rdata",  p0_rdata, 32'd0);
      chk("rst_p1_rdata",  p1_rdata, 32'd0);
      step;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step;
         chk($sformatf("idle_strobes_%0d", i), {28'd0, p1_ack, p0_ack, mem_wr, mem_rd}, 32'd0);
      end

      run("p0_wr5",  0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0);
      run("p0_rd5",  0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);
      run("p1_wr6",  1, 1'b1, 32'd6, 32'h12345678, 32'd0, 1'b0);
      run("p1_wr7",  1, 1'b1, 32'd7, 32'hAAAA5555, 32'd0, 1'b0);

      // Both ports held: fixed priority keeps granting port 0.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd5;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd6;
      for (int t = 0; t < 4; t++) begin
         step;
         chk($sformatf("sim%0d_access_addr", t), mem_addr, 32'd5);
         chk($sformatf("sim%0d_access_rd", t), {31'd0, mem_rd}, 32'd1);
         step;
         chk($sformatf("sim%0d_p0_ack", t), {31'd0, p0_ack}, 32'd1);
         chk($sformatf("sim%0d_p1_ack", t), {31'd0, p1_ack}, 32'd0);
         chk($sformatf("sim%0d_p0_rdata", t), p0_rdata, 32'hDEADBEEF);
         if (t == 3) p0_req = 1'b0;
         step;
      end

      // Port 1 now alone and held across its ack: ACCESS at N+1, N+4; ack at N+2, N+5.
      step;
      chk("b2b_access1_addr", mem_addr, 32'd6);
      chk("b2b_access1_rd", {31'd0, mem_rd}, 32'd1);
      step;
      chk("b2b_ack1", {30'd0, p1_ack, p0_ack}, 32'd2);
      chk("b2b_rdata1", p1_rdata, 32'h12345678);
      p1_addr = 32'd5;
      step;
      chk("b2b_idle_n3", {29'd0, p1_ack, p0_ack, mem_rd}, 32'd0);
      step;
      chk("b2b_access2_rd_n4", {31'd0, mem_rd}, 32'd1);
      chk("b2b_access2_addr", mem_addr, 32'd5);
      step;
      chk("b2b_ack2_n5", {30'd0, p1_ack, p0_ack}, 32'd2);
      chk("b2b_rdata2", p1_rdata, 32'hDEADBEEF);
      p1_req = 1'b0;
      step;
      chk("b2b_idle_after", {31'd0, p1_ack}, 32'd0);

      run("p1_oor", 1, 1'b0, 32'h400, 32'd0, 32'd0, 1'b1);
      chk("oor_p0_rdata_kept", p0_rdata, 32'hDEADBEEF);

      // Reset during ACCESS of a write: strobe drops at once, no ack, no memory update.
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd7; p0_wdata = 32'h0BAD0BAD;
      step;
      chk("midrst_access_wr", {31'd0, mem_wr}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_wr_drop", {31'd0, mem_wr}, 32'd0);
      chk("midrst_addr_clr", mem_addr, 32'd0);
      p0_req = 1'b0;
      step;
      step;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         chk($sformatf("midrst_no_ack_%0d", i), {28'd0, p1_ack, p0_ack, mem_wr, mem_rd}, 32'd0);
      end
      run("post_rst_rd7", 1, 1'b0, 32'd7, 32'd0, 32'hAAAA5555, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
